// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one buart transmitter between two byte-stream requesters. The
// transmitter is granted to one requester at a time (round-robin on ties)
// and held for a whole message, delimited by the requester's last flag. A
// lock timeout revokes the grant from an owner that stalls mid-message.
//
// Ports
//   clk_i           system clock
//   resetq_i        synchronous active-low reset
//   reqN_data_i     requester N byte
//   reqN_valid_i    requester N has a byte
//   reqN_last_i     byte is the final byte of its message
//   reqN_ready_o    byte accepted when valid && ready
//   uart_busy_i     buart busy
//   uart_wr_o       single-cycle write strobe to buart
//   uart_tx_data_o  byte for buart, valid while uart_wr_o is high
//   grant_o         one-hot owner, 00 when the transmitter is free
//   lock_timeout_o  one-cycle pulse when a grant is revoked
module uart_tx_arbiter #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int TO_W         = 16
) (
    input  logic       clk_i,
    input  logic       resetq_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_valid_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic [7:0] req1_data_i,
    input  logic       req1_valid_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    input  logic       uart_busy_i,
    output logic       uart_wr_o,
    output logic [7:0] uart_tx_data_o,
    output logic [1:0] grant_o,
    output logic       lock_timeout_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_ISSUE,
        S_SETTLE,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic            prio_q;       // 0: req0 wins a tie, 1: req1 wins
    logic [1:0]      grant_q;
    logic            uart_wr_q;
    logic [7:0]      tx_data_q;
    logic            lock_timeout_q;
    logic [TO_W-1:0] cnt_q;
    logic            last_q;

    // Owner view of the granted requester (grant_q[1] selects req1).
    logic            owner_d;
    logic            owner_valid_d;
    logic [7:0]      owner_data_d;
    logic            owner_last_d;
    logic            pick1_d;      // IDLE arbitration result
    logic            accept_d;

    assign owner_d       = grant_q[1];
    assign owner_valid_d = owner_d ? req1_valid_i : req0_valid_i;
    assign owner_data_d  = owner_d ? req1_data_i  : req0_data_i;
    assign owner_last_d  = owner_d ? req1_last_i  : req0_last_i;
    assign pick1_d       = req1_valid_i && (!req0_valid_i || prio_q);
    assign accept_d      = owner_valid_d && !uart_busy_i;

    // Ready depends only on state, grant and busy, never on valid.
    assign req0_ready_o = (state_q == S_READY) && grant_q[0] && !uart_busy_i;
    assign req1_ready_o = (state_q == S_READY) && grant_q[1] && !uart_busy_i;

    assign uart_wr_o      = uart_wr_q;
    assign uart_tx_data_o = tx_data_q;
    assign grant_o        = grant_q;
    assign lock_timeout_o = lock_timeout_q;

    always_ff @(posedge clk_i) begin
        if (!resetq_i) begin
            state_q        <= S_IDLE;
            prio_q         <= 1'b0;
            grant_q        <= 2'b00;
            uart_wr_q      <= 1'b0;
            tx_data_q      <= 8'h00;
            lock_timeout_q <= 1'b0;
            cnt_q          <= '0;
            last_q         <= 1'b0;
        end else begin
            uart_wr_q      <= 1'b0;
            lock_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0_valid_i || req1_valid_i) begin
                        grant_q <= pick1_d ? 2'b10 : 2'b01;
                        cnt_q   <= '0;
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    if (accept_d) begin
                        // Strobe is raised on entry so it is high exactly in ISSUE.
                        tx_data_q <= owner_data_d;
                        last_q    <= owner_last_d;
                        uart_wr_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_ISSUE;
                    end else if (!owner_valid_d && cnt_q == TO_LAST) begin
                        lock_timeout_q <= 1'b1;
                        grant_q        <= 2'b00;
                        prio_q         <= !owner_d;
                        cnt_q          <= '0;
                        state_q        <= S_IDLE;
                    end else if (!owner_valid_d && !uart_busy_i && cnt_q != TO_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    // buart raises busy one cycle after wr; skip that cycle.
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!uart_busy_i) begin
                        if (last_q) begin
                            grant_q <= 2'b00;
                            prio_q  <= !owner_d;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_READY;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
